neuron_argmax: RTL and testbench

- Downstream stage of the dot-product engine; serially consumes the NEURONS per-neuron dot-product values of one image (one "frame").
- Tracks the signed maximum and emits the winning class index, its value, a framing-error flag and a running frame count through a valid/ready output.
- Sits between the dot-product engine and the result/scoreboard logic.

---
 rtl/neuron_argmax_if.sv | 28 ++
 rtl/neuron_argmax.sv | 126 ++++++++++++
 tb/tb_neuron_argmax.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/neuron_argmax_if.sv
// Stream handshake between the dot-product engine, the argmax stage and the result consumer.
// The argmax block takes the slave view; whatever drives frames and drains results takes the master view.
interface neuron_argmax_if #(
  parameter int VAL_SIZE       = 26,
  parameter int IDX_SIZE       = 4,
  parameter int FRAME_CNT_SIZE = 16
);
  logic                      in_valid;
  logic [VAL_SIZE-1:0]       in_value;
  logic                      in_last;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [IDX_SIZE-1:0]       out_class;
  logic [VAL_SIZE-1:0]       out_value;
  logic                      out_err;
  logic [FRAME_CNT_SIZE-1:0] out_frames;

  modport slave (
    input  in_valid, in_value, in_last, out_ready,
    output in_ready, out_valid, out_class, out_value, out_err, out_frames
  );

  modport master (
    output in_valid, in_value, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_value, out_err, out_frames
  );
endinterface

// File: rtl/neuron_argmax.sv
// Serial signed argmax over the NEURONS dot-product values of one frame; the result is
// held on a valid/ready port until taken, and completed handoffs are counted.
module neuron_argmax #(
  parameter int NEURONS        = 10,
  parameter int VAL_SIZE       = 26,
  parameter int IDX_SIZE       = 4,
  parameter int FRAME_CNT_SIZE = 16
) (
  input logic            clk,
  input logic            GlobalReset,
  neuron_argmax_if.slave bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(NEURONS - 1);

  state_t                    state_reg, state_next;
  logic [IDX_SIZE-1:0]       cnt_reg, cnt_next;
  logic [IDX_SIZE-1:0]       idx_reg, idx_next;
  logic [VAL_SIZE-1:0]       best_reg, best_next;
  logic                      err_reg, err_next;
  logic                      out_valid_reg, out_valid_next;
  logic [IDX_SIZE-1:0]       out_class_reg, out_class_next;
  logic [VAL_SIZE-1:0]       out_value_reg, out_value_next;
  logic                      out_err_reg, out_err_next;
  logic [FRAME_CNT_SIZE-1:0] out_frames_reg, out_frames_next;

  logic in_ready;
  logic accept;
  logic last_beat;
  logic take;

  // Reset forces in_ready low combinationally so no beat is accepted in a reset cycle.
  assign in_ready  = (state_reg == COLLECT) & ~GlobalReset;
  assign accept    = bus.in_valid & in_ready;
  assign last_beat = (cnt_reg == LAST_IDX);
  // Strict greater-than keeps the lowest index on ties; beat 0 always seeds the running max.
  assign take      = (cnt_reg == '0) | ($signed(bus.in_value) > $signed(best_reg));

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_reg      <= COLLECT;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      best_reg       <= '0;
      err_reg        <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_class_reg  <= '0;
      out_value_reg  <= '0;
      out_err_reg    <= 1'b0;
      out_frames_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      best_reg       <= best_next;
      err_reg        <= err_next;
      out_valid_reg  <= out_valid_next;
      out_class_reg  <= out_class_next;
      out_value_reg  <= out_value_next;
      out_err_reg    <= out_err_next;
      out_frames_reg <= out_frames_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    best_next       = best_reg;
    err_next        = err_reg;
    out_valid_next  = out_valid_reg;
    out_class_next  = out_class_reg;
    out_value_next  = out_value_reg;
    out_err_next    = out_err_reg;
    out_frames_next = out_frames_reg;

    case (state_reg)
      COLLECT: begin
        if (accept) begin
          if (cnt_reg == '0) begin
            err_next = 1'b0;
          end
          if (take) begin
            best_next = bus.in_value;
            idx_next  = cnt_reg;
          end
          // The closing beat is either flagged last or the NEURONS-th; any disagreement is a framing error.
          if (bus.in_last | last_beat) begin
            err_next       = bus.in_last ^ last_beat;
            state_next     = HOLD;
            cnt_next       = '0;
            out_valid_next = 1'b1;
            out_class_next = idx_next;
            out_value_next = best_next;
            out_err_next   = err_next;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next      = COLLECT;
          out_valid_next  = 1'b0;
          out_frames_next = out_frames_reg + 1'b1;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_class  = out_class_reg;
  assign bus.out_value  = out_value_reg;
  assign bus.out_err    = out_err_reg;
  assign bus.out_frames = out_frames_reg;

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed bench for neuron_argmax; a second instance with a 3-bit frame counter runs in lockstep
// on the same inputs so counter wrap-around is observed within a short run.
module tb_neuron_argmax;

  localparam int NEURONS = 10;
  localparam int VS      = 26;
  localparam int IS      = 4;

  logic clk;
  logic GlobalReset;

  neuron_argmax_if #(.VAL_SIZE(VS), .IDX_SIZE(IS), .FRAME_CNT_SIZE(16)) bus ();
  neuron_argmax_if #(.VAL_SIZE(VS), .IDX_SIZE(IS), .FRAME_CNT_SIZE(3))  wbus ();

  neuron_argmax #(.NEURONS(NEURONS), .VAL_SIZE(VS), .IDX_SIZE(IS), .FRAME_CNT_SIZE(16)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .bus         (bus.slave)
  );

  neuron_argmax #(.NEURONS(NEURONS), .VAL_SIZE(VS), .IDX_SIZE(IS), .FRAME_CNT_SIZE(3)) dut_wrap (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .bus         (wbus.slave)
  );

  assign wbus.in_valid  = bus.in_valid;
  assign wbus.in_value  = bus.in_value;
  assign wbus.in_last   = bus.in_last;
  assign wbus.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  logic signed [VS-1:0] stim [0:15];

  task automatic load(input int v [10]);
    for (int i = 0; i < 10; i++) stim[i] = VS'(v[i]);
  endtask

  // Presents n beats back to back; returns on the negedge right after the last beat's edge.
  task automatic feed(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_value = stim[i];
      bus.in_last  = (i == last_at);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    GlobalReset   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if ({bus.out_class, bus.out_value, bus.out_err} !== '0) begin errors++; $display("FAIL reset_outputs got class=%0d value=%0d err=%b want 0", bus.out_class, bus.out_value, bus.out_err); end
    checks++; if (bus.out_frames !== 16'd0) begin errors++; $display("FAIL reset_frames got=%0d want=0", bus.out_frames); end
    GlobalReset = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready); end
    $display("reset: done");
  endtask

  task automatic test_nominal();
    load('{5, -3, 100, 7, 0, 2, 99, 1, -50, 3});
    feed(10, 9);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nom_latency out_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL nom_hold_in_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.out_class !== 4'd2 || bus.out_value !== VS'(100) || bus.out_err !== 1'b0) begin errors++; $display("FAIL nom_result got class=%0d value=%0d err=%b want class=2 value=100 err=0", bus.out_class, $signed(bus.out_value), bus.out_err); end
    checks++; if (bus.out_frames !== 16'(exp_frames)) begin errors++; $display("FAIL nom_frames_before got=%0d want=%0d", bus.out_frames, exp_frames); end
    $display("nominal: class=%0d value=%0d err=%b", bus.out_class, $signed(bus.out_value), bus.out_err);
    @(negedge clk);
    exp_frames++;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_frames !== 16'(exp_frames)) begin errors++; $display("FAIL nom_handoff got valid=%b frames=%0d want valid=0 frames=%0d", bus.out_valid, bus.out_frames, exp_frames); end
  endtask

  task automatic test_ties();
    load('{-10, -2, -2, -7, -9, -20, -3, -100, -5, -8});
    feed(10, 9);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd1 || bus.out_value !== VS'(-2) || bus.out_err !== 1'b0) begin errors++; $display("FAIL tie_neg got valid=%b class=%0d value=%0d err=%b want valid=1 class=1 value=-2 err=0", bus.out_valid, bus.out_class, $signed(bus.out_value), bus.out_err); end
    $display("negative tie: class=%0d value=%0d", bus.out_class, $signed(bus.out_value));
    @(negedge clk);
    exp_frames++;
    load('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    feed(10, 9);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd0 || bus.out_value !== VS'(0)) begin errors++; $display("FAIL tie_zero got valid=%b class=%0d value=%0d want valid=1 class=0 value=0", bus.out_valid, bus.out_class, $signed(bus.out_value)); end
    $display("all-zero tie: class=%0d value=%0d", bus.out_class, $signed(bus.out_value));
    @(negedge clk);
    exp_frames++;
    checks++; if (bus.out_frames !== 16'(exp_frames)) begin errors++; $display("FAIL tie_frames got=%0d want=%0d", bus.out_frames, exp_frames); end
  endtask

  task automatic test_backpressure();
    int bad;
    bus.out_ready = 1'b0;
    load('{1, 2, 3, 4, 5, 6, 7, 8, 9, -1});
    feed(10, 9);
    // Stray input while holding must be ignored.
    bus.in_valid = 1'b1;
    bus.in_value = VS'(1000);
    bus.in_last  = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_class, bus.out_value, bus.out_err, bus.out_frames} !==
          {1'b0, 1'b1, 4'd8, VS'(9), 1'b0, 16'(exp_frames)}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got ready=%b valid=%b class=%0d value=%0d frames=%0d want ready=0 valid=1 class=8 value=9 frames=%0d",
                 c, bus.in_ready, bus.out_valid, bus.out_class, $signed(bus.out_value), bus.out_frames, exp_frames);
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_frames++;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_frames !== 16'(exp_frames)) begin errors++; $display("FAIL bp_release got ready=%b valid=%b frames=%0d want ready=1 valid=0 frames=%0d", bus.in_ready, bus.out_valid, bus.out_frames, exp_frames); end
    checks++; if (bus.out_class !== 4'd8 || bus.out_value !== VS'(9)) begin errors++; $display("FAIL bp_keep got class=%0d value=%0d want class=8 value=9", bus.out_class, $signed(bus.out_value)); end
    $display("backpressure: released, frames=%0d", bus.out_frames);
    load('{0, 1, 2, 3, 4, 5, 6, 7, 8, 50});
    feed(10, 9);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd9 || bus.out_value !== VS'(50) || bus.out_err !== 1'b0) begin errors++; $display("FAIL bp_second got valid=%b class=%0d value=%0d err=%b want valid=1 class=9 value=50 err=0", bus.out_valid, bus.out_class, $signed(bus.out_value), bus.out_err); end
    $display("backpressure second frame: class=%0d value=%0d", bus.out_class, $signed(bus.out_value));
    @(negedge clk);
    exp_frames++;
  endtask

  task automatic test_framing();
    stim[0] = VS'(1); stim[1] = VS'(9); stim[2] = VS'(3); stim[3] = VS'(4);
    feed(4, 3);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd1 || bus.out_value !== VS'(9) || bus.out_err !== 1'b1) begin errors++; $display("FAIL frm_early got valid=%b class=%0d value=%0d err=%b want valid=1 class=1 value=9 err=1", bus.out_valid, bus.out_class, $signed(bus.out_value), bus.out_err); end
    $display("early last: class=%0d value=%0d err=%b", bus.out_class, $signed(bus.out_value), bus.out_err);
    @(negedge clk);
    exp_frames++;
    load('{4, 3, 2, 1, 0, -1, -2, -3, -4, -5});
    feed(10, -1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd0 || bus.out_value !== VS'(4) || bus.out_err !== 1'b1) begin errors++; $display("FAIL frm_missing got valid=%b class=%0d value=%0d err=%b want valid=1 class=0 value=4 err=1", bus.out_valid, bus.out_class, $signed(bus.out_value), bus.out_err); end
    $display("missing last: class=%0d value=%0d err=%b", bus.out_class, $signed(bus.out_value), bus.out_err);
    @(negedge clk);
    exp_frames++;
    load('{5, -3, 100, 7, 0, 2, 99, 1, -50, 3});
    feed(10, 9);
    checks++; if (bus.out_class !== 4'd2 || bus.out_value !== VS'(100) || bus.out_err !== 1'b0) begin errors++; $display("FAIL frm_good got class=%0d value=%0d err=%b want class=2 value=100 err=0", bus.out_class, $signed(bus.out_value), bus.out_err); end
    $display("good after errors: class=%0d err=%b", bus.out_class, bus.out_err);
    @(negedge clk);
    exp_frames++;
    checks++; if (bus.out_frames !== 16'(exp_frames)) begin errors++; $display("FAIL frm_frames got=%0d want=%0d", bus.out_frames, exp_frames); end
  endtask

  task automatic test_mid_reset();
    stim[0] = VS'(3); stim[1] = VS'(1); stim[2] = VS'(1000);
    stim[3] = VS'(2); stim[4] = VS'(2); stim[5] = VS'(2);
    feed(6, -1);
    GlobalReset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_comb got=%b want=0", bus.in_ready); end
    @(negedge clk);
    checks++; if ({bus.in_ready, bus.out_valid, bus.out_class, bus.out_value, bus.out_err, bus.out_frames} !== '0) begin errors++; $display("FAIL rst_outputs got ready=%b valid=%b class=%0d value=%0d err=%b frames=%0d want all 0", bus.in_ready, bus.out_valid, bus.out_class, $signed(bus.out_value), bus.out_err, bus.out_frames); end
    GlobalReset = 1'b0;
    exp_frames  = 0;
    $display("mid-frame reset applied");
    load('{1, 2, 3, 4, 50, 6, 7, 8, 9, 10});
    feed(10, 9);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd4 || bus.out_value !== VS'(50) || bus.out_err !== 1'b0) begin errors++; $display("FAIL rst_post_frame got valid=%b class=%0d value=%0d err=%b want valid=1 class=4 value=50 err=0", bus.out_valid, bus.out_class, $signed(bus.out_value), bus.out_err); end
    $display("post-reset frame: class=%0d value=%0d", bus.out_class, $signed(bus.out_value));
    @(negedge clk);
    exp_frames++;
    checks++; if (bus.out_frames !== 16'(exp_frames)) begin errors++; $display("FAIL rst_frames got=%0d want=%0d", bus.out_frames, exp_frames); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 10; j++) stim[j] = VS'(j - 20);
      stim[k % 10] = VS'(200 + k);
      feed(10, 9);
      checks++; if (bus.out_class !== IS'(k % 10) || bus.out_value !== VS'(200 + k) || wbus.out_class !== IS'(k % 10) || wbus.out_value !== VS'(200 + k)) begin errors++; $display("FAIL wrap_result frame=%0d got class=%0d/%0d value=%0d/%0d want class=%0d value=%0d", k, bus.out_class, wbus.out_class, $signed(bus.out_value), $signed(wbus.out_value), k % 10, 200 + k); end
      @(negedge clk);
      exp_frames++;
      checks++; if (bus.out_frames !== 16'(exp_frames) || wbus.out_frames !== 3'(exp_frames % 8)) begin errors++; $display("FAIL wrap_count frame=%0d got frames=%0d small=%0d want frames=%0d small=%0d", k, bus.out_frames, wbus.out_frames, exp_frames, exp_frames % 8); end
      $display("wrap frame %0d: class=%0d frames=%0d small_counter=%0d", k, bus.out_class, bus.out_frames, wbus.out_frames);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ties();
    test_backpressure();
    test_framing();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
